// File: rtl/arith_reservation_station.sv
// Collapsing-queue reservation station feeding arithmetic_pipeline: captures operands
// and flags from the CDB and issues the oldest fully ready micro-op once per cycle.
module arith_reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_opcode,
    input  logic [TAG_W-1:0] disp_rob,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic [TAG_W-1:0] disp_flag_reg,
    input  logic             disp_a_rdy,
    input  logic             disp_b_rdy,
    input  logic             disp_f_rdy,
    input  logic [TAG_W-1:0] disp_a_tag,
    input  logic [TAG_W-1:0] disp_b_tag,
    input  logic [TAG_W-1:0] disp_f_tag,
    input  logic [7:0]       disp_a_val,
    input  logic [7:0]       disp_b_val,
    input  logic [7:0]       disp_f_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [7:0]       cdb_val,
    output logic [3:0]       opcode,
    output logic [TAG_W-1:0] ROB_entry,
    output logic [TAG_W-1:0] dest_reg,
    output logic [TAG_W-1:0] flag_reg,
    output logic [7:0]       op_a_val,
    output logic [7:0]       op_b_val,
    output logic [7:0]       flags_val,
    output logic             instr_valid
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       opcode;
        logic [TAG_W-1:0] rob;
        logic [TAG_W-1:0] dest;
        logic [TAG_W-1:0] flg;
        logic             a_rdy;
        logic [TAG_W-1:0] a_tag;
        logic [7:0]       a_val;
        logic             b_rdy;
        logic [TAG_W-1:0] b_tag;
        logic [7:0]       b_val;
        logic             f_rdy;
        logic [TAG_W-1:0] f_tag;
        logic [7:0]       f_val;
    } entry_t;

    entry_t           slots [DEPTH];
    entry_t           woken [DEPTH];
    entry_t           nxt   [DEPTH];
    entry_t           new_entry;
    entry_t           issue_entry;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    wr_idx;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready_vec;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             do_disp;

    assign disp_ready = (count < CW'(DEPTH));
    assign do_disp    = disp_valid && disp_ready && !flush;

    // Selection looks only at registered ready bits, so a wakeup issues one edge later.
    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = '0;
        issue_entry = slots[0];
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]     = (CW'(i) < count);
            ready_vec[i] = valid[i] && slots[i].a_rdy && slots[i].b_rdy && slots[i].f_rdy;
            if (!sel_found && ready_vec[i]) begin
                sel_found   = 1'b1;
                sel_idx     = IW'(i);
                issue_entry = slots[i];
            end
        end
    end

    always_comb begin
        new_entry        = '0;
        new_entry.opcode = disp_opcode;
        new_entry.rob    = disp_rob;
        new_entry.dest   = disp_dest;
        new_entry.flg    = disp_flag_reg;
        new_entry.a_tag  = disp_a_tag;
        new_entry.b_tag  = disp_b_tag;
        new_entry.f_tag  = disp_f_tag;
        new_entry.a_rdy  = disp_a_rdy || (cdb_valid && disp_a_tag == cdb_tag);
        new_entry.b_rdy  = disp_b_rdy || (cdb_valid && disp_b_tag == cdb_tag);
        new_entry.f_rdy  = disp_f_rdy || (cdb_valid && disp_f_tag == cdb_tag);
        new_entry.a_val  = disp_a_rdy ? disp_a_val : cdb_val;
        new_entry.b_val  = disp_b_rdy ? disp_b_val : cdb_val;
        new_entry.f_val  = disp_f_rdy ? disp_f_val : cdb_val;
    end

    // Wakeup first, then collapse over the issued slot, then append the dispatch at the new tail.
    always_comb begin
        wr_idx     = count - CW'(sel_found);
        count_next = count + CW'(do_disp) - CW'(sel_found);
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = slots[i];
            if (cdb_valid && valid[i]) begin
                if (!slots[i].a_rdy && slots[i].a_tag == cdb_tag) begin
                    woken[i].a_rdy = 1'b1;
                    woken[i].a_val = cdb_val;
                end
                if (!slots[i].b_rdy && slots[i].b_tag == cdb_tag) begin
                    woken[i].b_rdy = 1'b1;
                    woken[i].b_val = cdb_val;
                end
                if (!slots[i].f_rdy && slots[i].f_tag == cdb_tag) begin
                    woken[i].f_rdy = 1'b1;
                    woken[i].f_val = cdb_val;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = woken[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (sel_found && IW'(i) >= sel_idx) begin
                nxt[i] = woken[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && CW'(i) == wr_idx) begin
                nxt[i] = new_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            instr_valid <= 1'b0;
            opcode      <= '0;
            ROB_entry   <= '0;
            dest_reg    <= '0;
            flag_reg    <= '0;
            op_a_val    <= '0;
            op_b_val    <= '0;
            flags_val   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            count       <= '0;
            instr_valid <= 1'b0;
        end else begin
            count       <= count_next;
            instr_valid <= sel_found;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= nxt[i];
            end
            if (sel_found) begin
                opcode    <= issue_entry.opcode;
                ROB_entry <= issue_entry.rob;
                dest_reg  <= issue_entry.dest;
                flag_reg  <= issue_entry.flg;
                op_a_val  <= issue_entry.a_val;
                op_b_val  <= issue_entry.b_val;
                flags_val <= issue_entry.f_val;
            end
        end
    end
endmodule

// File: tb/tb_arith_reservation_station.sv
// Bench for arith_reservation_station: directed scenarios plus random traffic,
// checked against a queue-based model of the station's dispatch/wakeup/issue rules.
module tb_arith_reservation_station;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_opcode;
    logic [TAG_W-1:0] disp_rob, disp_dest, disp_flag_reg;
    logic             disp_a_rdy, disp_b_rdy, disp_f_rdy;
    logic [TAG_W-1:0] disp_a_tag, disp_b_tag, disp_f_tag;
    logic [7:0]       disp_a_val, disp_b_val, disp_f_val;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [7:0]       cdb_val;
    logic [3:0]       opcode;
    logic [TAG_W-1:0] ROB_entry, dest_reg, flag_reg;
    logic [7:0]       op_a_val, op_b_val, flags_val;
    logic             instr_valid;

    arith_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob(disp_rob), .disp_dest(disp_dest),
        .disp_flag_reg(disp_flag_reg),
        .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy), .disp_f_rdy(disp_f_rdy),
        .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_f_tag(disp_f_tag),
        .disp_a_val(disp_a_val), .disp_b_val(disp_b_val), .disp_f_val(disp_f_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .opcode(opcode), .ROB_entry(ROB_entry), .dest_reg(dest_reg), .flag_reg(flag_reg),
        .op_a_val(op_a_val), .op_b_val(op_b_val), .flags_val(flags_val),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [TAG_W-1:0] rob, dest, flg;
        logic             ar, br, fr;
        logic [TAG_W-1:0] at, bt, ft;
        logic [7:0]       av, bv, fv;
    } m_t;

    m_t               mq[$];
    logic             e_valid;
    logic [3:0]       e_op;
    logic [TAG_W-1:0] e_rob, e_dest, e_flg;
    logic [7:0]       e_a, e_b, e_f;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("instr_valid", 32'(instr_valid), 32'(e_valid));
        checkOutput("opcode", 32'(opcode), 32'(e_op));
        checkOutput("rob_entry", 32'(ROB_entry), 32'(e_rob));
        checkOutput("dest_reg", 32'(dest_reg), 32'(e_dest));
        checkOutput("flag_reg", 32'(flag_reg), 32'(e_flg));
        checkOutput("op_a_val", 32'(op_a_val), 32'(e_a));
        checkOutput("op_b_val", 32'(op_b_val), 32'(e_b));
        checkOutput("flags_val", 32'(flags_val), 32'(e_f));
    endtask

    task automatic clearModel();
        mq.delete();
        e_valid = 1'b0; e_op = '0; e_rob = '0; e_dest = '0; e_flg = '0;
        e_a = '0; e_b = '0; e_f = '0;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic setDisp(input logic [3:0] op, input logic [TAG_W-1:0] rob, input logic [TAG_W-1:0] dest,
                           input logic [TAG_W-1:0] flg,
                           input logic ar, input logic [TAG_W-1:0] at, input logic [7:0] av,
                           input logic br, input logic [TAG_W-1:0] bt, input logic [7:0] bv,
                           input logic fr, input logic [TAG_W-1:0] ft, input logic [7:0] fv);
        disp_valid = 1'b1; disp_opcode = op; disp_rob = rob; disp_dest = dest; disp_flag_reg = flg;
        disp_a_rdy = ar; disp_a_tag = at; disp_a_val = av;
        disp_b_rdy = br; disp_b_tag = bt; disp_b_val = bv;
        disp_f_rdy = fr; disp_f_tag = ft; disp_f_val = fv;
    endtask

    task automatic setCdb(input logic [TAG_W-1:0] tag, input logic [7:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
    endtask

    // One clock edge: predict from the model using the current inputs, then compare after the edge.
    task automatic applyStimulus();
        int   sel;
        logic accept;
        m_t   t;
        checkOutput("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
        sel    = -1;
        accept = disp_valid && (mq.size() < DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            e_valid = 1'b0;
        end else begin
            for (int i = 0; i < mq.size(); i++)
                if (sel < 0 && mq[i].ar && mq[i].br && mq[i].fr) sel = i;
            if (sel >= 0) begin
                e_valid = 1'b1; e_op = mq[sel].op; e_rob = mq[sel].rob; e_dest = mq[sel].dest;
                e_flg = mq[sel].flg; e_a = mq[sel].av; e_b = mq[sel].bv; e_f = mq[sel].fv;
            end else begin
                e_valid = 1'b0;
            end
            if (cdb_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    t = mq[i];
                    if (!t.ar && t.at == cdb_tag) begin t.ar = 1'b1; t.av = cdb_val; end
                    if (!t.br && t.bt == cdb_tag) begin t.br = 1'b1; t.bv = cdb_val; end
                    if (!t.fr && t.ft == cdb_tag) begin t.fr = 1'b1; t.fv = cdb_val; end
                    mq[i] = t;
                end
            end
            if (sel >= 0) mq.delete(sel);
            if (accept) begin
                t.op = disp_opcode; t.rob = disp_rob; t.dest = disp_dest; t.flg = disp_flag_reg;
                t.at = disp_a_tag; t.bt = disp_b_tag; t.ft = disp_f_tag;
                t.ar = disp_a_rdy || (cdb_valid && disp_a_tag == cdb_tag);
                t.br = disp_b_rdy || (cdb_valid && disp_b_tag == cdb_tag);
                t.fr = disp_f_rdy || (cdb_valid && disp_f_tag == cdb_tag);
                t.av = disp_a_rdy ? disp_a_val : cdb_val;
                t.bv = disp_b_rdy ? disp_b_val : cdb_val;
                t.fv = disp_f_rdy ? disp_f_val : cdb_val;
                mq.push_back(t);
            end
        end
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        setDisp(4'h0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        disp_valid = 1'b0;
        cdb_tag = '0; cdb_val = '0;
        clearModel();
        #2;
        compareAll();
        checkOutput("reset_ready", 32'(disp_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;

        // All-ready dispatch issues on the following edge, for exactly one cycle.
        setDisp(4'h0, 5'd1, 5'd2, 5'hF, 1'b1, 5'd0, 8'h01, 1'b1, 5'd0, 8'h02, 1'b1, 5'd0, 8'hFF);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("s1_issue", 32'(instr_valid), 32'd1);
        checkOutput("s1_a", 32'(op_a_val), 32'h01);
        checkOutput("s1_f", 32'(flags_val), 32'hFF);
        applyStimulus();
        checkOutput("s1_once", 32'(instr_valid), 32'd0);

        // Operand A waits on tag 7; a tag-8 broadcast must not wake it.
        setDisp(4'h3, 5'd2, 5'd3, 5'd4, 1'b0, 5'd7, 8'h00, 1'b1, 5'd0, 8'h10, 1'b1, 5'd0, 8'h20);
        applyStimulus();
        idle(); setCdb(5'd8, 8'h99);
        applyStimulus();
        idle(); setCdb(5'd7, 8'h55);
        applyStimulus();
        checkOutput("s2_wait", 32'(instr_valid), 32'd0);
        idle();
        applyStimulus();
        checkOutput("s2_issue", 32'(instr_valid), 32'd1);
        checkOutput("s2_a", 32'(op_a_val), 32'h55);
        applyStimulus();

        // Fill the station, then release everything with one broadcast.
        for (int r = 1; r <= 4; r++) begin
            setDisp(4'h1, 5'(r), 5'(r + 8), 5'(r + 16), 1'b0, 5'd3, 8'h00,
                    1'b1, 5'd0, 8'(r), 1'b1, 5'd0, 8'h00);
            applyStimulus();
        end
        idle();
        checkOutput("s3_full", 32'(disp_ready), 32'd0);
        setCdb(5'd3, 8'h33);
        applyStimulus();
        idle();
        for (int r = 1; r <= 4; r++) begin
            applyStimulus();
            checkOutput("s3_iv", 32'(instr_valid), 32'd1);
            checkOutput("s3_order", 32'(ROB_entry), 32'(r));
            if (r == 1) checkOutput("s3_ready_back", 32'(disp_ready), 32'd1);
        end
        applyStimulus();

        // Younger ready entries bypass an older waiting one.
        setDisp(4'h2, 5'd5, 5'd1, 5'd1, 1'b1, 5'd0, 8'h0A, 1'b0, 5'd9, 8'h00, 1'b1, 5'd0, 8'h00);
        applyStimulus();
        setDisp(4'h4, 5'd6, 5'd1, 5'd1, 1'b1, 5'd0, 8'h0B, 1'b1, 5'd0, 8'h0C, 1'b1, 5'd0, 8'h00);
        applyStimulus();
        setDisp(4'h5, 5'd7, 5'd1, 5'd1, 1'b1, 5'd0, 8'h0D, 1'b1, 5'd0, 8'h0E, 1'b1, 5'd0, 8'h00);
        applyStimulus();
        checkOutput("s4_first", 32'(ROB_entry), 32'd6);
        idle();
        applyStimulus();
        checkOutput("s4_second", 32'(ROB_entry), 32'd7);
        setCdb(5'd9, 8'h99);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("s4_old", 32'(ROB_entry), 32'd5);
        checkOutput("s4_b", 32'(op_b_val), 32'h99);
        applyStimulus();

        // Same-edge CDB bypass into a dispatching entry.
        setDisp(4'h6, 5'd8, 5'd2, 5'd3, 1'b0, 5'd5, 8'h00, 1'b1, 5'd0, 8'h01, 1'b1, 5'd0, 8'h02);
        setCdb(5'd5, 8'hAA);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("s5_iv", 32'(instr_valid), 32'd1);
        checkOutput("s5_a", 32'(op_a_val), 32'hAA);

        // Flush with three held entries; a later broadcast must not resurrect them.
        for (int r = 0; r < 3; r++) begin
            setDisp(4'h7, 5'(20 + r), 5'd0, 5'd0, 1'b0, 5'd12, 8'h00,
                    1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
            applyStimulus();
        end
        setDisp(4'h7, 5'd30, 5'd0, 5'd0, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        setCdb(5'd12, 8'hC0);
        flush = 1'b1;
        applyStimulus();
        checkOutput("s6_flush_iv", 32'(instr_valid), 32'd0);
        idle();
        setCdb(5'd12, 8'hC1);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("s6_no_issue", 32'(instr_valid), 32'd0);

        // Asynchronous reset asserted between edges while an issue is showing.
        setDisp(4'h9, 5'd11, 5'd4, 5'd5, 1'b1, 5'd0, 8'h44, 1'b1, 5'd0, 8'h45, 1'b1, 5'd0, 8'h46);
        applyStimulus();
        idle();
        applyStimulus();
        checkOutput("s7_pre_iv", 32'(instr_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        clearModel();
        compareAll();
        checkOutput("s7_ready", 32'(disp_ready), 32'd1);
        #1 rst = 1'b0;

        // Random traffic on a small tag space so wakeups hit often.
        repeat (400) begin
            idle();
            flush = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 70) begin
                setDisp(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 99) < 40) setCdb(5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            applyStimulus();
        end
        idle();
        repeat (6) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
